ship_placement: RTL
===================

Name: ship_placement

Overview:
- Stage directly downstream of the ship-count decision stage in the Battleship controller.
- Once ships_decided asserts, it runs an interactive placement session. The player moves a cursor over a 5x5 board and drops single-cell ships until the confirmed count is placed.
- Outputs the player's occupancy board and a done flag consumed by the game/attack FSM.

Parameters:
- ROWS, 5, board rows
- COLS, 5, board columns
- MAX_SHIPS, 5, upper bound on ships per player

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ships_decided  input  1  level from decision stage; starts placement
- player_amount_ships  input  3  requested ship count
- btn_up  input  1  raw move-up button (already synchronised)
- btn_down  input  1  move-down button
- btn_left  input  1  move-left button
- btn_right  input  1  move-right button
- btn_place  input  1  place-ship button
- cursor_row  output  3  current cursor row, 0..ROWS-1
- cursor_col  output  3  current cursor column, 0..COLS-1
- player_board  output  ROWS*COLS  occupancy; bit index = row*COLS+col
- ships_placed  output  3  ships placed so far
- placing  output  1  high in PLACE state
- place_error  output  1  one-cycle pulse on attempt to place on an occupied cell
- placement_done  output  1  all ships placed; held until rst

Behaviour:
- One clock; synchronous active-high reset on clk.
- Reset values:
  - state=IDLE
  - cursor_row=0, cursor_col=0
  - player_board=0, ships_placed=0
  - placing=0, place_error=0, placement_done=0
  - all button history registers=0
- Button handling: each button passes through a rising-edge detector (edge = btn & ~btn_q).
  - A button held high acts once only.
  - The edge is evaluated at posedge k. Its effect is visible on outputs after posedge k (1-cycle latency from the sampled edge).
- FSM states: IDLE, PLACE, DONE.
- IDLE:
  - If ships_decided=1 and player_amount_ships!=0, latch the target, go to PLACE.
  - Target = min(player_amount_ships, MAX_SHIPS).
  - Cursor and board cleared on entry.
  - Count 0 is ignored; the FSM stays in IDLE.
- PLACE:
  - Moves saturate at board edges; there is no wrap. Up at row 0 and right at col COLS-1 are no-ops.
  - Simultaneous move edges: only the highest-priority move applies. Priority is up > down > left > right.
  - Place edge on an empty cell: set the board bit and increment ships_placed.
  - Place edge on an occupied cell: no board change; place_error=1 for exactly one cycle.
  - Move and place edges in the same cycle: the place uses the pre-move cursor, and the move also applies.
  - When the increment makes ships_placed == target, go to DONE on the same edge.
  - ships_decided dropping during PLACE does not abort placement.
- DONE:
  - placement_done=1, placing=0.
  - Board, cursor and count frozen; all buttons ignored.
  - Exit only via rst.
- Reset mid-operation: any state returns to the full reset values on the next posedge, and the board is lost.
- Width rules:
  - Board index is computed as row*COLS+col in 5 bits.
  - ships_placed never exceeds target, so it never exceeds MAX_SHIPS.

Decomposition:
- Package battleship_pkg holds:
  - ROWS, COLS, MAX_SHIPS constants
  - board_t, a (ROWS*COLS)-bit packed type
  - place_state_t enum {IDLE, PLACE, DONE}
  - cell-index helper function
- One sub-module, btn_edge (clk, rst, btn, edge): a single-register rising-edge detector, instantiated five times.

Test Plan:
- rst, ships_decided=1, amount=3, then place at (0,0), right-edge, place, down-edge, place → board bits 0,1,6 set; ships_placed=3; placement_done=1 one cycle after the third edge.
- In PLACE, hold btn_place high 10 cycles on an empty cell → exactly one bit set, ships_placed=1, no place_error.
- Place at (2,2), then place again at (2,2) → bit 12 stays set, ships_placed=1, place_error high for exactly one cycle.
- Cursor at (0,0): up and left edges → stays (0,0). Apply 6 down edges and 6 right edges → (4,4); a further right edge leaves (4,4).
- Same-cycle up+right edges from (2,2) → (1,2). Place+down at (1,2) → bit 7 set and cursor becomes (2,2).
- amount=7 → target clamps to 5, done after the 5th placement. amount=0 → stays IDLE. rst asserted mid-PLACE with 2 ships placed → board=0, cursor (0,0), IDLE next cycle.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared board geometry, placement FSM states and cell indexing for the Battleship controller.
// No logic of its own; pure types and constants.
// No flow control.
package battleship_pkg;

    localparam int ROWS      = 5;
    localparam int COLS      = 5;
    localparam int MAX_SHIPS = 5;
    localparam int CELLS     = ROWS * COLS;

    typedef logic [CELLS-1:0] board_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLACE = 2'd1,
        DONE  = 2'd2
    } place_state_t;

    // Row-major cell index; 5 bits covers all 25 cells.
    function automatic logic [4:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
        return 5'(row) * 5'(COLS) + 5'(col);
    endfunction

endpackage

// File: rtl/ship_placement_btn_edge.sv
// Rising-edge detector for one already-synchronised button.
// Combinational pulse in the cycle the button is first seen high; one history register.
// No flow control; a held button yields a single pulse.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic r_btn_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_q <= 1'b0;
        end else begin
            r_btn_q <= btn;
        end
    end

    assign pulse = btn & ~r_btn_q;

endmodule

// File: rtl/ship_placement.sv
// Interactive single-cell ship placement on a 5x5 board after the ship count is decided.
// Button edge sampled at a posedge is visible on outputs right after that posedge.
// No flow control; DONE holds the board and flag until rst.
module ship_placement
    import battleship_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ships_decided,
    input  logic [2:0]            player_amount_ships,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_place,
    output logic [2:0]            cursor_row,
    output logic [2:0]            cursor_col,
    output logic [ROWS*COLS-1:0]  player_board,
    output logic [2:0]            ships_placed,
    output logic                  placing,
    output logic                  place_error,
    output logic                  placement_done
);

    logic w_up_edge;
    logic w_down_edge;
    logic w_left_edge;
    logic w_right_edge;
    logic w_place_edge;

    btn_edge u_edge_up    (.clk(clk), .rst(rst), .btn(btn_up),    .pulse(w_up_edge));
    btn_edge u_edge_down  (.clk(clk), .rst(rst), .btn(btn_down),  .pulse(w_down_edge));
    btn_edge u_edge_left  (.clk(clk), .rst(rst), .btn(btn_left),  .pulse(w_left_edge));
    btn_edge u_edge_right (.clk(clk), .rst(rst), .btn(btn_right), .pulse(w_right_edge));
    btn_edge u_edge_place (.clk(clk), .rst(rst), .btn(btn_place), .pulse(w_place_edge));

    place_state_t r_state;
    logic [2:0]   r_row;
    logic [2:0]   r_col;
    board_t       r_board;
    logic [2:0]   r_count;
    logic [2:0]   r_target;
    logic         r_err;

    place_state_t w_state_nxt;
    logic [2:0]   w_row_nxt;
    logic [2:0]   w_col_nxt;
    board_t       w_board_nxt;
    logic [2:0]   w_count_nxt;
    logic [2:0]   w_target_nxt;
    logic         w_err_nxt;
    logic [4:0]   w_idx;
    logic [2:0]   w_count_inc;

    assign w_idx       = cell_idx(r_row, r_col);
    assign w_count_inc = r_count + 3'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        w_board_nxt  = r_board;
        w_count_nxt  = r_count;
        w_target_nxt = r_target;
        w_err_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (ships_decided && (player_amount_ships != 3'd0)) begin
                    w_target_nxt = (player_amount_ships > 3'(MAX_SHIPS)) ? 3'(MAX_SHIPS)
                                                                          : player_amount_ships;
                    w_row_nxt    = 3'd0;
                    w_col_nxt    = 3'd0;
                    w_board_nxt  = '0;
                    w_count_nxt  = 3'd0;
                    w_state_nxt  = PLACE;
                end
            end

            PLACE: begin
                // Placement looks at the pre-move cursor; a same-cycle move still applies.
                if (w_place_edge) begin
                    if (r_board[w_idx]) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_board_nxt[w_idx] = 1'b1;
                        w_count_nxt        = w_count_inc;
                        if (w_count_inc == r_target) begin
                            w_state_nxt = DONE;
                        end
                    end
                end

                if (w_up_edge) begin
                    if (r_row != 3'd0) w_row_nxt = r_row - 3'd1;
                end else if (w_down_edge) begin
                    if (r_row != 3'(ROWS-1)) w_row_nxt = r_row + 3'd1;
                end else if (w_left_edge) begin
                    if (r_col != 3'd0) w_col_nxt = r_col - 3'd1;
                end else if (w_right_edge) begin
                    if (r_col != 3'(COLS-1)) w_col_nxt = r_col + 3'd1;
                end
            end

            DONE: begin
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_row    <= 3'd0;
            r_col    <= 3'd0;
            r_board  <= '0;
            r_count  <= 3'd0;
            r_target <= 3'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            r_board  <= w_board_nxt;
            r_count  <= w_count_nxt;
            r_target <= w_target_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign cursor_row     = r_row;
    assign cursor_col     = r_col;
    assign player_board   = r_board;
    assign ships_placed   = r_count;
    assign placing        = (r_state == PLACE);
    assign place_error    = r_err;
    assign placement_done = (r_state == DONE);

endmodule
